// File: rtl/replay_reader_pkg.sv
// Shared constants, FSM state type and the sample-unpack helper for the
// DDR IQ playback reader.
//   BURST_LEN / BURST_BYTES : 16 beats x 8 bytes per AR burst
//   AXI_* : fixed AR channel attributes (INCR, 64-bit, modifiable/bufferable)
//   unpack_sample : pulls sample idx out of a 64-bit word in 8- or 16-bit packing
package replay_reader_pkg;

  localparam int         BURST_LEN      = 16;
  localparam int         BURST_BYTES    = 128;
  localparam logic [3:0] AXI_ARLEN      = 4'(BURST_LEN - 1);
  localparam logic [2:0] AXI_ARSIZE     = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_ARCACHE    = 4'b0011;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  typedef struct packed {
    logic [11:0] re;
    logic [11:0] im;
  } sample_t;

  // 16-bit packing: two samples per word, each a 12-bit value in the low
  // bits of a 16-bit lane. 8-bit packing: four byte pairs, left-justified.
  function automatic sample_t unpack_sample(input logic [63:0] w,
                                            input logic [1:0]  idx,
                                            input logic        mode8);
    sample_t s;
    int      base;
    base = mode8 ? 16 * int'(idx) : 32 * int'(idx[0]);
    if (mode8) begin
      s.re = {w[base +: 8], 4'b0};
      s.im = {w[base + 8 +: 8], 4'b0};
    end else begin
      s.re = w[base +: 12];
      s.im = w[base + 16 +: 12];
    end
    return s;
  endfunction

endpackage

// File: rtl/replay_reader_if.sv
// AXI3 read-address and read-data channels used by the playback reader.
//   master : the reader (drives AR*, RREADY)
//   slave  : the memory / interconnect side (drives ARREADY, R*)
interface replay_reader_if;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [1:0]  ARLOCK;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, ARLOCK, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, ARLOCK, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/replay_beat_fifo.sv
// Synchronous read-data FIFO with show-ahead read port and occupancy count.
//   clk, rst_n   : clock, async active-low reset
//   flush_i      : drop all contents (pointers back to zero)
//   wr_en_i/wr_data_i : push one beat
//   rd_en_i/rd_data_o : pop head beat; rd_data_o is valid while !empty_o
//   empty_o, count_o  : status
module replay_beat_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, wr_en_i} - {{AW{1'b0}}, rd_en_i};
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
endmodule

// File: rtl/replay_reader.sv
// AXI3 read master that plays back IQ recordings from DDR as a sample stream.
//   clk, rst_n          : clock, async active-low reset
//   start/stop          : begin playback (latches addresses, mode) / abort
//   mode_8bit           : packing of the recording, sampled at start
//   start/end_address   : 128-byte aligned byte range, end exclusive
//   busy, finished      : status; finished pulses as playback ends
//   rd_error            : sticky non-OKAY RRESP flag, cleared by start
//   next_address        : address of the next AR burst
//   re_out/im_out, valid_out, ready_in : output sample stream
//   axi                 : AR/R channels (master side)
module replay_reader
  import replay_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode_8bit,
  input  logic [31:0]           start_address,
  input  logic [31:0]           end_address,
  output logic                  busy,
  output logic                  finished,
  output logic                  rd_error,
  output logic [31:0]           next_address,
  output logic [11:0]           re_out,
  output logic [11:0]           im_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  replay_reader_if.master       axi
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTST + 1);
  // An AR may go out only if the beats already held plus those promised
  // leave room for a whole burst, so RREADY can stay high unconditionally.
  localparam logic [CW+1:0] CREDIT_LIMIT = (CW+2)'(FIFO_DEPTH - BURST_LEN);

  state_e        state_q, state_d;
  logic          abort_q, mode8_q, arvalid_q, rd_error_q;
  logic [31:0]   next_addr_q, end_addr_q;
  logic [OW-1:0] outst_q;
  logic [CW:0]   resv_q;
  logic [63:0]   word_q;
  logic [1:0]    idx_q, rem_q;
  sample_t       out_q;
  logic          out_vld_q;

  logic          ar_hs, r_hs, start_acc, stop_acc, at_end, credit_ok, ar_issue;
  logic          drain_done, unpack_empty, out_free, pop, fifo_wr;
  logic          fifo_empty;
  logic [63:0]   fifo_rdata;
  logic [CW:0]   fifo_count;

  assign ar_hs     = arvalid_q && axi.ARREADY;
  assign r_hs      = axi.RVALID && axi.RREADY;
  assign start_acc = (state_q == ST_IDLE) && start && !stop;
  assign stop_acc  = (state_q != ST_IDLE) && stop;
  assign at_end    = (next_addr_q == end_addr_q);
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, resv_q}) <= CREDIT_LIMIT;
  assign ar_issue  = (state_q == ST_RUN) && !stop && !at_end && !arvalid_q &&
                     (outst_q < OW'(MAX_OUTST)) && credit_ok;

  assign unpack_empty = !out_vld_q && (rem_q == 2'd0);
  // An aborted run only waits for the bus to settle; buffered data is dropped.
  assign drain_done   = (outst_q == '0) && !arvalid_q &&
                        (abort_q || (fifo_empty && unpack_empty));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_acc)      state_d = ST_RUN;
      ST_RUN:   if (stop || at_end) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done)     state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    finished = 1'b0;
    unique case (state_q)
      ST_RUN:   busy = 1'b1;
      ST_DRAIN: begin
        busy     = 1'b1;
        finished = drain_done;
      end
      default: ;
    endcase
  end

  // ---------------- AR issue, credit, outstanding ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q <= '0;
      end_addr_q  <= '0;
      mode8_q     <= 1'b0;
      abort_q     <= 1'b0;
      arvalid_q   <= 1'b0;
      outst_q     <= '0;
      resv_q      <= '0;
      rd_error_q  <= 1'b0;
    end else begin
      if (start_acc) begin
        next_addr_q <= start_address;
        end_addr_q  <= end_address;
        mode8_q     <= mode_8bit;
      end else if (ar_hs) begin
        next_addr_q <= next_addr_q + 32'(BURST_BYTES);
      end

      if (start_acc)     abort_q <= 1'b0;
      else if (stop_acc) abort_q <= 1'b1;

      // Once raised, ARVALID holds (even across an abort) until accepted.
      if (ar_hs)         arvalid_q <= 1'b0;
      else if (ar_issue) arvalid_q <= 1'b1;

      unique case ({ar_hs, r_hs && axi.RLAST})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: ;
      endcase

      resv_q <= resv_q + (ar_hs ? (CW+1)'(BURST_LEN) : '0) - {{CW{1'b0}}, r_hs};

      if (start_acc)                        rd_error_q <= 1'b0;
      else if (r_hs && axi.RRESP != 2'b00)  rd_error_q <= 1'b1;
    end
  end

  assign axi.ARADDR  = next_addr_q;
  assign axi.ARLEN   = AXI_ARLEN;
  assign axi.ARSIZE  = AXI_ARSIZE;
  assign axi.ARBURST = AXI_BURST_INCR;
  assign axi.ARCACHE = AXI_ARCACHE;
  assign axi.ARPROT  = 3'b000;
  assign axi.ARLOCK  = 2'b00;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = busy;

  // ---------------- beat buffer ----------------
  assign fifo_wr = r_hs && !abort_q && !stop_acc;

  replay_beat_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (stop_acc),
    .wr_en_i   (fifo_wr),
    .wr_data_i (axi.RDATA),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // ---------------- unpacker / output register ----------------
  // Sample 0 goes straight from the FIFO head into the output register; the
  // word is kept so the remaining samples follow on later cycles.
  assign out_free = !out_vld_q || ready_in;
  assign pop      = out_free && (rem_q == 2'd0) && !fifo_empty && !abort_q && !stop_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (stop_acc) begin
      rem_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (out_free) begin
      if (rem_q != 2'd0) begin
        out_q     <= unpack_sample(word_q, idx_q, mode8_q);
        idx_q     <= idx_q + 1'b1;
        rem_q     <= rem_q - 1'b1;
        out_vld_q <= 1'b1;
      end else if (pop) begin
        out_q     <= unpack_sample(fifo_rdata, 2'd0, mode8_q);
        word_q    <= fifo_rdata;
        idx_q     <= 2'd1;
        rem_q     <= mode8_q ? 2'd3 : 2'd1;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign re_out       = out_q.re;
  assign im_out       = out_q.im;
  assign valid_out    = out_vld_q;
  assign rd_error     = rd_error_q;
  assign next_address = next_addr_q;
endmodule

// File: tb/tb_replay_reader.sv
module tb_replay_reader;
  import replay_reader_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, mode_8bit = 1'b0, ready_in = 1'b1;
  logic [31:0] start_address = '0, end_address = '0;
  logic        busy, finished, rd_error, valid_out;
  logic [31:0] next_address;
  logic [11:0] re_out, im_out;

  replay_reader_if axi();

  logic        arready_tb = 1'b1, rvalid_tb = 1'b0, rlast_tb = 1'b0;
  logic [63:0] rdata_tb = '0;
  logic [1:0]  rresp_tb = '0;
  assign axi.ARREADY = arready_tb;
  assign axi.RVALID  = rvalid_tb;
  assign axi.RLAST   = rlast_tb;
  assign axi.RDATA   = rdata_tb;
  assign axi.RRESP   = rresp_tb;

  replay_reader #(.FIFO_DEPTH(32), .MAX_OUTST(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_8bit(mode_8bit),
    .start_address(start_address), .end_address(end_address),
    .busy(busy), .finished(finished), .rd_error(rd_error), .next_address(next_address),
    .re_out(re_out), .im_out(im_out), .valid_out(valid_out), .ready_in(ready_in),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          ar_cnt = 0, fin_cnt = 0, n_out = 0, beat_i = 0;
  logic [31:0] ar_log[$];
  logic [31:0] ar_q[$];
  logic [23:0] exp_q[$];
  bit          rvalid_en = 1'b1, mem_const = 1'b0;
  logic [31:0] err_addr = '1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Recording pattern: 12-bit values counting up by beat address, junk in the
  // upper nibbles of every 16-bit lane.
  function automatic logic [11:0] s12(input logic [31:0] a, input int k);
    logic [31:0] v;
    v = (a >> 3) * 4 + 32'(k) + 32'h123;
    return v[11:0];
  endfunction

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (mem_const) return 64'h8001_7F02_0304_0506;
    return {4'hA, s12(a, 3), 4'hB, s12(a, 2), 4'hC, s12(a, 1), 4'hD, s12(a, 0)};
  endfunction

  task automatic push16(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [31:0] a = lo; a < hi; a += 8) begin
      exp_q.push_back({s12(a, 0), s12(a, 1)});
      exp_q.push_back({s12(a, 2), s12(a, 3)});
    end
  endtask

  task automatic push8(input int nbeats);
    repeat (nbeats) begin
      exp_q.push_back(24'h060_050);
      exp_q.push_back(24'h040_030);
      exp_q.push_back(24'h020_7F0);
      exp_q.push_back(24'h010_800);
    end
  endtask

  // ---------------- AXI slave model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && axi.ARVALID && axi.ARREADY) begin
        ar_q.push_back(axi.ARADDR);
        ar_log.push_back(axi.ARADDR);
        ar_cnt++;
        chk("ar_attrs", {axi.ARLEN, axi.ARSIZE, axi.ARBURST, axi.ARCACHE, axi.ARPROT, axi.ARLOCK},
            {4'd15, 3'd3, 2'd1, 4'b0011, 3'd0, 2'd0});
      end
    end
  end

  initial begin
    bit          take;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      take = rvalid_tb && axi.RREADY;
      @(posedge clk); #1;
      if (!rst_n) begin
        ar_q.delete();
        beat_i = 0; rvalid_tb = 1'b0; rlast_tb = 1'b0;
      end else begin
        if (take) begin
          if (beat_i == 15) begin ar_q.delete(0); beat_i = 0; end
          else beat_i++;
          rvalid_tb = 1'b0;
        end
        if (!rvalid_tb && ar_q.size() > 0 && rvalid_en) begin
          a         = ar_q[0] + 32'(beat_i * 8);
          rdata_tb  = mem_word(a);
          rlast_tb  = (beat_i == 15);
          rresp_tb  = (a == err_addr) ? 2'b10 : 2'b00;
          rvalid_tb = 1'b1;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_out && ready_in) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sample: got 0x%0h, expected none", {re_out, im_out});
        end else begin
          e = exp_q.pop_front();
          chk("sample", {re_out, im_out}, e);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && finished) fin_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play(input logic [31:0] sa, input logic [31:0] ea, input logic m8);
    start_address = sa; end_address = ea; mode_8bit = m8; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_outputs(input string name, input int target, input int budget);
    int n = 0;
    while (n_out < target && n < budget) begin tick(); n++; end
    chk(name, n_out >= target, 1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_finished"}, finished, 0);
    chk({p, "_rd_error"}, rd_error, 0);
    chk({p, "_valid_out"}, valid_out, 0);
    chk({p, "_arvalid"}, axi.ARVALID, 0);
    chk({p, "_rready"}, axi.RREADY, 0);
    chk({p, "_next_address"}, next_address, 0);
    chk({p, "_re_im"}, {re_out, im_out}, 0);
  endtask

  initial begin
    int ar0, fin0, out0;
    tick(3);
    chk_reset("reset");
    rst_n = 1'b1;
    tick(2);

    // 16-bit, two bursts
    ar0 = ar_cnt; fin0 = fin_cnt; out0 = n_out; ar_log.delete();
    push16(32'h1000, 32'h1100);
    play(32'h1000, 32'h1100, 1'b0);
    wait_idle("t1", 600); tick(2);
    chk("t1_ar_count", ar_cnt - ar0, 2);
    chk("t1_ar0_addr", (ar_log.size() > 0) ? ar_log[0] : 32'hFFFF_FFFF, 32'h1000);
    chk("t1_ar1_addr", (ar_log.size() > 1) ? ar_log[1] : 32'hFFFF_FFFF, 32'h1080);
    chk("t1_samples", n_out - out0, 64);
    chk("t1_exp_left", exp_q.size(), 0);
    chk("t1_finished", fin_cnt - fin0, 1);
    chk("t1_next_address", next_address, 32'h1100);

    // 8-bit, one burst of a fixed word
    mem_const = 1'b1; fin0 = fin_cnt; out0 = n_out;
    push8(16);
    play(32'h2000, 32'h2080, 1'b1);
    wait_idle("t2", 600); tick(2);
    chk("t2_samples", n_out - out0, 64);
    chk("t2_exp_left", exp_q.size(), 0);
    chk("t2_finished", fin_cnt - fin0, 1);
    mem_const = 1'b0;

    // downstream stall over a large span
    ready_in = 1'b0; ar0 = ar_cnt; fin0 = fin_cnt; out0 = n_out;
    push16(32'h0010_0000, 32'h0010_0400);
    play(32'h0010_0000, 32'h0020_0000, 1'b0);
    tick(200);
    chk("t3_ar_during_stall", ar_cnt - ar0, 2);
    chk("t3_hold_valid", valid_out, 1);
    chk("t3_hold_sample", {re_out, im_out}, {12'h123, 12'h124});
    ready_in = 1'b1;
    wait_outputs("t3_resume", out0 + 96, 2000);
    chk("t3_ar_resumed", (ar_cnt - ar0) > 2, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t3_valid_after_stop", valid_out, 0);
    wait_idle("t3", 600); tick(2);
    exp_q.delete();
    chk("t3_finished", fin_cnt - fin0, 1);
    chk("t3_bursts_drained", ar_q.size(), 0);

    // stop with two bursts outstanding and no data yet
    rvalid_en = 1'b0; ar0 = ar_cnt; fin0 = fin_cnt; out0 = n_out;
    play(32'h8000, 32'h1_0000, 1'b0);
    tick(10);
    chk("t4_outstanding", ar_cnt - ar0, 2);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t4_valid_low", valid_out, 0);
    chk("t4_rready_held", axi.RREADY, 1);
    chk("t4_busy_held", busy, 1);
    tick(3);
    chk("t4_no_early_finish", fin_cnt - fin0, 0);
    rvalid_en = 1'b1;
    wait_idle("t4", 600); tick(2);
    chk("t4_bursts_done", ar_q.size(), 0);
    chk("t4_ar_total", ar_cnt - ar0, 2);
    chk("t4_finished", fin_cnt - fin0, 1);
    chk("t4_no_samples", n_out - out0, 0);

    // SLVERR on one beat
    err_addr = 32'h3040; out0 = n_out;
    push16(32'h3000, 32'h3080);
    play(32'h3000, 32'h3080, 1'b0);
    wait_idle("t5a", 600); tick(2);
    chk("t5_rd_error_set", rd_error, 1);
    chk("t5_samples", n_out - out0, 32);
    chk("t5_exp_left", exp_q.size(), 0);
    err_addr = '1;
    push16(32'h3080, 32'h3100);
    play(32'h3080, 32'h3100, 1'b0);
    chk("t5_rd_error_cleared", rd_error, 0);
    wait_idle("t5b", 600); tick(2);
    chk("t5b_exp_left", exp_q.size(), 0);

    // empty range
    ar0 = ar_cnt; fin0 = fin_cnt;
    play(32'h4000, 32'h4000, 1'b0);
    wait_idle("t6", 50); tick(2);
    chk("t6_no_ar", ar_cnt - ar0, 0);
    chk("t6_finished", fin_cnt - fin0, 1);

    // start and stop together while idle
    ar0 = ar_cnt; fin0 = fin_cnt;
    start_address = 32'h4000; end_address = 32'h4100;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    tick(5);
    chk("t7_busy", busy, 0);
    chk("t7_no_ar", ar_cnt - ar0, 0);
    chk("t7_no_finish", fin_cnt - fin0, 0);

    // reset mid-burst, then a clean playback
    out0 = n_out;
    push16(32'h5000, 32'h5200);
    play(32'h5000, 32'h6000, 1'b0);
    wait_outputs("t8_running", out0 + 10, 600);
    #2 rst_n = 1'b0;
    #1 chk_reset("t8_async");
    tick(3);
    exp_q.delete();
    rst_n = 1'b1;
    tick(2);
    fin0 = fin_cnt; out0 = n_out;
    push16(32'h1000, 32'h1100);
    play(32'h1000, 32'h1100, 1'b0);
    wait_idle("t8", 600); tick(2);
    chk("t8_samples", n_out - out0, 64);
    chk("t8_exp_left", exp_q.size(), 0);
    chk("t8_finished", fin_cnt - fin0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
